// File: rtl/bullet_frame_scheduler.sv
// Bullet table with a shadow copy for game logic and an active copy for the renderer, committed one slot per clk at frame end.
// Hit outputs lag p_tick by 1 clk; wr_ready drops for the SLOTS-clk commit, and requesters hold their write until it returns.
module bullet_frame_scheduler #(
    parameter int SLOTS = 4,
    parameter int SIZE  = 8,
    parameter int OFFX  = 220,
    parameter int OFFY  = 140
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p_tick,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2:0]       wr_slot,
    input  logic [15:0]      wr_pos,
    input  logic [1:0]       wr_color,
    input  logic             wr_en,
    input  logic             clear_all,
    output logic             hit,
    output logic [1:0]       hit_color,
    output logic [2:0]       hit_slot,
    output logic [SLOTS-1:0] active_mask,
    output logic [7:0]       frame_count,
    output logic             commit_done
);

    localparam int IW = $clog2(SLOTS);

    typedef struct packed {
        logic        en;
        logic [1:0]  color;
        logic [15:0] pos;
    } slot_t;

    typedef enum logic {ST_RUN, ST_COMMIT} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    slot_t         shadow [SLOTS];
    slot_t         active [SLOTS];

    logic          frame_end;
    logic          wr_fire;
    logic          visible;
    logic [10:0]   x11;
    logic [10:0]   y11;
    logic [SLOTS-1:0] box_hit;
    logic          any_hit;
    logic [2:0]    win_slot;
    logic [1:0]    win_color;

    assign frame_end = p_tick && (x == 10'd639) && (y == 10'd479);
    assign wr_fire   = wr_valid && wr_ready;
    assign visible   = (x < 10'd640) && (y < 10'd480);
    assign x11       = {1'b0, x};
    assign y11       = {1'b0, y};

    // 11-bit compares keep boxes near the origin from wrapping to the far edge.
    for (genvar g = 0; g < SLOTS; g++) begin : g_box
        logic [10:0] bx;
        logic [10:0] by;
        assign bx = {3'b000, active[g].pos[15:8]} + 11'(OFFX);
        assign by = {3'b000, active[g].pos[7:0]} + 11'(OFFY);
        assign box_hit[g] = active[g].en
                          && (x11 + 11'(SIZE) >= bx) && (x11 <= bx + 11'(SIZE))
                          && (y11 + 11'(SIZE) >= by) && (y11 <= by + 11'(SIZE));
        assign active_mask[g] = active[g].en;
    end

    always_comb begin
        any_hit   = 1'b0;
        win_slot  = 3'd0;
        win_color = 2'd0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (box_hit[i]) begin
                any_hit   = 1'b1;
                win_slot  = 3'(i);
                win_color = active[i].color;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            idx         <= '0;
            wr_ready    <= 1'b0;
            frame_count <= 8'd0;
            commit_done <= 1'b0;
            hit         <= 1'b0;
            hit_color   <= 2'd0;
            hit_slot    <= 3'd0;
            for (int i = 0; i < SLOTS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            commit_done <= 1'b0;
            case (state)
                ST_RUN: begin
                    wr_ready <= !frame_end;
                    if (frame_end) begin
                        state <= ST_COMMIT;
                        idx   <= '0;
                    end
                    // Clear first so a same-edge write keeps its own enable.
                    for (int i = 0; i < SLOTS; i++) begin
                        if (clear_all)
                            shadow[i].en <= 1'b0;
                        if (wr_fire && (wr_slot == 3'(i))) begin
                            shadow[i].en    <= wr_en && (wr_color != 2'd3);
                            shadow[i].color <= wr_color;
                            shadow[i].pos   <= wr_pos;
                        end
                    end
                end
                ST_COMMIT: begin
                    for (int i = 0; i < SLOTS; i++) begin
                        if (idx == IW'(i))
                            active[i] <= shadow[i];
                    end
                    idx <= idx + IW'(1);
                    if (idx == IW'(SLOTS - 1)) begin
                        state       <= ST_RUN;
                        wr_ready    <= 1'b1;
                        frame_count <= frame_count + 8'd1;
                        commit_done <= 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase

            if (p_tick) begin
                hit       <= any_hit && visible;
                hit_color <= visible ? win_color : 2'd0;
                hit_slot  <= visible ? win_slot : 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_bullet_frame_scheduler.sv
// Bench for bullet_frame_scheduler: default-offset instance plus a zero-offset instance sharing all inputs.
module tb_bullet_frame_scheduler;

    localparam int SLOTS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_tick;
    logic [9:0]  x, y;
    logic        wr_valid;
    logic [2:0]  wr_slot;
    logic [15:0] wr_pos;
    logic [1:0]  wr_color;
    logic        wr_en;
    logic        clear_all;

    logic             wr_ready_a, hit_a, commit_done_a;
    logic [1:0]       hit_color_a;
    logic [2:0]       hit_slot_a;
    logic [SLOTS-1:0] active_mask_a;
    logic [7:0]       frame_count_a;

    logic             wr_ready_z, hit_z, commit_done_z;
    logic [1:0]       hit_color_z;
    logic [2:0]       hit_slot_z;
    logic [SLOTS-1:0] active_mask_z;
    logic [7:0]       frame_count_z;

    bullet_frame_scheduler #(.SLOTS(SLOTS)) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .x(x), .y(y),
        .wr_valid(wr_valid), .wr_ready(wr_ready_a), .wr_slot(wr_slot), .wr_pos(wr_pos),
        .wr_color(wr_color), .wr_en(wr_en), .clear_all(clear_all),
        .hit(hit_a), .hit_color(hit_color_a), .hit_slot(hit_slot_a),
        .active_mask(active_mask_a), .frame_count(frame_count_a), .commit_done(commit_done_a)
    );

    bullet_frame_scheduler #(.SLOTS(SLOTS), .OFFX(0), .OFFY(0)) dut_z (
        .clk(clk), .reset(reset), .p_tick(p_tick), .x(x), .y(y),
        .wr_valid(wr_valid), .wr_ready(wr_ready_z), .wr_slot(wr_slot), .wr_pos(wr_pos),
        .wr_color(wr_color), .wr_en(wr_en), .clear_all(clear_all),
        .hit(hit_z), .hit_color(hit_color_z), .hit_slot(hit_slot_z),
        .active_mask(active_mask_z), .frame_count(frame_count_z), .commit_done(commit_done_z)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit    sel;
        bit    hit;
        int    slot;
        int    col;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   fc_model = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pixel probe: expectation queued with the stimulus, checked when the registered result appears.
    task automatic probe(input bit sel, input int px, input int py, input bit eh,
                         input int es, input int ec, input string tag);
        exp_t e;
        exp_t o;
        e.sel = sel; e.hit = eh; e.slot = es; e.col = ec; e.tag = tag;
        sb.push_back(e);
        x = 10'(px); y = 10'(py); p_tick = 1'b1;
        @(negedge clk);
        p_tick = 1'b0;
        o = sb.pop_front();
        if (o.sel) begin
            check_val({o.tag, "_hit"},   {31'd0, hit_z},       {31'd0, o.hit});
            check_val({o.tag, "_slot"},  {29'd0, hit_slot_z},  o.slot);
            check_val({o.tag, "_color"}, {30'd0, hit_color_z}, o.col);
        end else begin
            check_val({o.tag, "_hit"},   {31'd0, hit_a},       {31'd0, o.hit});
            check_val({o.tag, "_slot"},  {29'd0, hit_slot_a},  o.slot);
            check_val({o.tag, "_color"}, {30'd0, hit_color_a}, o.col);
        end
    endtask

    task automatic write_slot(input int slot, input logic [15:0] pos, input int col,
                              input bit en, input bit clr);
        int n;
        n = 0;
        wr_slot = 3'(slot); wr_pos = pos; wr_color = 2'(col); wr_en = en;
        wr_valid = 1'b1; clear_all = clr;
        while (wr_ready_a !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("wr_accept_wait_ok", {31'd0, (n < 20)}, 32'd1);
        @(negedge clk);
        wr_valid = 1'b0; clear_all = 1'b0;
    endtask

    // Drive the last visible pixel, then follow the commit; optionally hold a write across it.
    task automatic frame(input bit hold_wr);
        int low;
        x = 10'd639; y = 10'd479; p_tick = 1'b1;
        @(negedge clk);
        p_tick = 1'b0; x = 10'd0; y = 10'd0;
        if (hold_wr) wr_valid = 1'b1;
        low = 0;
        while (wr_ready_a === 1'b0 && low < 20) begin
            @(negedge clk);
            low++;
        end
        fc_model = (fc_model + 1) % 256;
        check_val("ready_low_clks", low, SLOTS);
        check_val("commit_done_pulse", {31'd0, commit_done_a}, 32'd1);
        check_val("frame_count", {24'd0, frame_count_a}, fc_model);
        check_val("frame_count_z", {24'd0, frame_count_z}, fc_model);
        @(negedge clk);
        wr_valid = 1'b0;
        check_val("commit_done_single", {31'd0, commit_done_a}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; p_tick = 1'b0; x = '0; y = '0;
        wr_valid = 1'b0; wr_slot = '0; wr_pos = '0; wr_color = '0; wr_en = 1'b0; clear_all = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_wr_ready",    {31'd0, wr_ready_a},    32'd0);
        check_val("rst_hit",         {31'd0, hit_a},         32'd0);
        check_val("rst_mask",        {28'd0, active_mask_a}, 32'd0);
        check_val("rst_frame_count", {24'd0, frame_count_a}, 32'd0);
        check_val("rst_commit_done", {31'd0, commit_done_a}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_val("post_rst_wr_ready", {31'd0, wr_ready_a}, 32'd1);

        // Test 1: single bullet, visible only after the commit.
        write_slot(0, 16'h1010, 0, 1'b1, 1'b0);
        check_val("t1_mask_pre", {28'd0, active_mask_a}, 32'd0);
        probe(0, 236, 156, 1'b0, 0, 0, "t1_pre_commit");
        frame(1'b0);
        check_val("t1_mask", {28'd0, active_mask_a}, 32'b0001);
        probe(0, 236, 156, 1'b1, 0, 0, "t1_centre");
        x = 10'd400;
        @(negedge clk);
        check_val("t1_held", {31'd0, hit_a}, 32'd1);
        probe(0, 245, 156, 1'b0, 0, 0, "t1_right_out");
        probe(0, 244, 148, 1'b1, 0, 0, "t1_corner_in");
        probe(0, 227, 156, 1'b0, 0, 0, "t1_left_out");

        // Test 2: overlap priority, then disabling via colour 3.
        write_slot(1, 16'h3030, 1, 1'b1, 1'b0);
        write_slot(2, 16'h3030, 2, 1'b1, 1'b0);
        frame(1'b0);
        probe(0, 268, 188, 1'b1, 1, 1, "t2_prio");
        write_slot(1, 16'h3030, 3, 1'b1, 1'b0);
        frame(1'b0);
        check_val("t2_mask", {28'd0, active_mask_a}, 32'b0101);
        probe(0, 268, 188, 1'b1, 2, 2, "t2_disabled");

        // Test 3: write held across the boundary lands in shadow after the commit.
        wr_slot = 3'd3; wr_pos = 16'h5050; wr_color = 2'd1; wr_en = 1'b1;
        frame(1'b1);
        check_val("t3_mask_same", {28'd0, active_mask_a}, 32'b0101);
        probe(0, 300, 220, 1'b0, 0, 0, "t3_not_yet");
        frame(1'b0);
        check_val("t3_mask_next", {28'd0, active_mask_a}, 32'b1101);
        probe(0, 300, 220, 1'b1, 3, 1, "t3_visible");

        // Test 4: clear_all with a same-edge write.
        write_slot(2, 16'h3030, 2, 1'b1, 1'b1);
        frame(1'b0);
        check_val("t4_mask", {28'd0, active_mask_a}, 32'b0100);
        probe(0, 268, 188, 1'b1, 2, 2, "t4_slot2");
        probe(0, 236, 156, 1'b0, 0, 0, "t4_slot0_gone");

        // Test 5: box at the origin with zero offsets; out-of-range slot dropped.
        write_slot(0, 16'h0000, 1, 1'b1, 1'b0);
        write_slot(5, 16'h1010, 1, 1'b1, 1'b0);
        frame(1'b0);
        check_val("t5_mask", {28'd0, active_mask_a}, 32'b0101);
        check_val("t5_mask_z", {28'd0, active_mask_z}, 32'b0101);
        probe(1, 0, 0, 1'b1, 0, 1, "t5_origin");
        probe(1, 8, 8, 1'b1, 0, 1, "t5_corner");
        probe(1, 9, 0, 1'b0, 0, 0, "t5_x9");
        probe(1, 0, 9, 1'b0, 0, 0, "t5_y9");
        probe(1, 1020, 0, 1'b0, 0, 0, "t5_nowrap");
        probe(0, 212, 132, 1'b1, 0, 1, "t5_offset_corner");
        probe(0, 211, 140, 1'b0, 0, 0, "t5_offset_out");

        // Test 6: reset in the middle of a commit.
        x = 10'd639; y = 10'd479; p_tick = 1'b1;
        @(negedge clk);
        p_tick = 1'b0; x = 10'd0; y = 10'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        fc_model = 0;
        check_val("t6_frame_count", {24'd0, frame_count_a}, 32'd0);
        check_val("t6_mask",        {28'd0, active_mask_a}, 32'd0);
        check_val("t6_wr_ready",    {31'd0, wr_ready_a},    32'd0);
        check_val("t6_hit",         {31'd0, hit_a},         32'd0);
        check_val("t6_commit_done", {31'd0, commit_done_a}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        frame(1'b0);
        check_val("t6_mask_empty", {28'd0, active_mask_a}, 32'd0);
        write_slot(0, 16'h1010, 2, 1'b1, 1'b0);
        frame(1'b0);
        check_val("t6_mask_after", {28'd0, active_mask_a}, 32'b0001);
        probe(0, 236, 156, 1'b1, 0, 2, "t6_hit_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
